// File: rtl/phase_sequencer.sv
// Programmable N-phase one-hot sequencer with run / halt-at-boundary / single-step control.
// Optional build macro PHASE_SEQ_GAP_EN inserts one dead clock after every phase.
module phase_sequencer #(
  parameter int NUM_PHASES = 2,
  parameter int DIV_WIDTH  = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  reset_bar,
  input  logic                  run,
  input  logic                  step,
  input  logic [DIV_WIDTH-1:0]  div,
  output logic [NUM_PHASES-1:0] phase_active,
  output logic [NUM_PHASES-1:0] phase_en,
  output logic                  cycle_start,
  output logic                  cycle_done,
  output logic                  halted,
  output logic [CNT_WIDTH-1:0]  cycle_count
);

  localparam int IDX_W = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PHASES - 1);

  typedef enum logic [1:0] {IDLE, RUN, STEP} state_t;

  state_t               state;
  logic [IDX_W-1:0]     phase_idx;
  logic [DIV_WIDTH-1:0] tick;
  logic [DIV_WIDTH-1:0] d_lat;
  logic [DIV_WIDTH-1:0] last_tick;
  logic                 phase_end;

  function automatic logic [DIV_WIDTH-1:0] clamp_div(input logic [DIV_WIDTH-1:0] v);
    return (v == '0) ? DIV_WIDTH'(1) : v;
  endfunction

  function automatic logic [NUM_PHASES-1:0] onehot(input logic [IDX_W-1:0] i);
    return NUM_PHASES'(1) << i;
  endfunction

  assign last_tick = d_lat - DIV_WIDTH'(1);

`ifdef PHASE_SEQ_GAP_EN
  logic in_gap;
  // A phase only hands over once its trailing dead clock has elapsed.
  assign phase_end = in_gap;
`else
  assign phase_end = (tick == last_tick);
`endif

  always_ff @(posedge clock or negedge reset_bar) begin
    if (!reset_bar) begin
      state        <= IDLE;
      phase_idx    <= '0;
      tick         <= '0;
      d_lat        <= '0;
      phase_active <= '0;
      phase_en     <= '0;
      cycle_start  <= 1'b0;
      cycle_done   <= 1'b0;
      halted       <= 1'b1;
      cycle_count  <= '0;
`ifdef PHASE_SEQ_GAP_EN
      in_gap       <= 1'b0;
`endif
    end else begin
      phase_en    <= '0;
      cycle_start <= 1'b0;
      cycle_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (run || step) begin
            state        <= run ? RUN : STEP;
            d_lat        <= clamp_div(div);
            phase_idx    <= '0;
            tick         <= '0;
            phase_active <= onehot('0);
            phase_en     <= onehot('0);
            cycle_start  <= 1'b1;
            halted       <= 1'b0;
          end
        end
        default: begin
          if (phase_end) begin
            tick <= '0;
`ifdef PHASE_SEQ_GAP_EN
            in_gap <= 1'b0;
`endif
            if (phase_idx != LAST_IDX) begin
              phase_idx    <= IDX_W'(phase_idx + 1'b1);
              phase_active <= onehot(IDX_W'(phase_idx + 1'b1));
              phase_en     <= onehot(IDX_W'(phase_idx + 1'b1));
            end else begin
              cycle_count <= cycle_count + 1'b1;
              cycle_done  <= 1'b1;
              phase_idx   <= '0;
              // Back-to-back cycles restart phase 0 on the same edge, no idle clock.
              if (state == RUN && run) begin
                d_lat        <= clamp_div(div);
                phase_active <= onehot('0);
                phase_en     <= onehot('0);
                cycle_start  <= 1'b1;
              end else begin
                state        <= IDLE;
                phase_active <= '0;
                halted       <= 1'b1;
              end
            end
          end else begin
`ifdef PHASE_SEQ_GAP_EN
            if (tick == last_tick) begin
              in_gap       <= 1'b1;
              phase_active <= '0;
            end else begin
              tick <= tick + 1'b1;
            end
`else
            tick <= tick + 1'b1;
`endif
          end
        end
      endcase
    end
  end

endmodule
